// File: rtl/led_drv_pkg.sv
// -----------------------------------------------------------------------------
// led_drv_pkg
// Shared definitions for the LED mode driver: mode encodings, default timing
// constants for the 50 MHz board and a small constant helper used to size the
// shared millisecond phase counter.
// Ports: none (package).
// Configuration macro: LED_BREATH_EN (consumed by led_mode_driver).
// -----------------------------------------------------------------------------
package led_drv_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_RUN    = 2'b10,
    MODE_BREATH = 2'b11
  } mode_e;

  localparam int DEF_TICK_DIV  = 50_000;
  localparam int DEF_BLINK_MS  = 250;
  localparam int DEF_RUN_MS    = 100;
  localparam int DEF_BREATH_MS = 8;
  localparam int DEF_PWM_STEPS = 64;

  // Largest of three periods; the phase counter must hold the longest one.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else       m = m;
    if (c > m) m = c;
    else       m = m;
    return m;
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    if (modulus > 1) return $clog2(modulus);
    else             return 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Divides the board clock into a one-cycle pulse every TICK_DIV clocks.
// The divider counts 0..TICK_DIV-1 and the registered pulse is high exactly
// for the cycle in which the counter holds TICK_DIV-1.
// Ports:
//   clk   in  1  board clock
//   rst   in  1  synchronous active-high reset
//   tick  out 1  registered one-cycle pulse per TICK_DIV clocks
// -----------------------------------------------------------------------------
module led_tick_gen
  import led_drv_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          tick_next;

  // Next divider value; the pulse is precomputed so it lines up with the
  // counter sitting on its last value.
  always_comb begin
    cnt_next  = cnt;
    tick_next = 1'b0;
    if (cnt == CNT_LAST) cnt_next = '0;
    else                 cnt_next = cnt + CW'(1);
    tick_next = (cnt_next == CNT_LAST);
  end

  // Divider and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= tick_next;
    end
  end

endmodule

// File: rtl/led_mode_driver.sv
// -----------------------------------------------------------------------------
// led_mode_driver
// Drives the board LEDs from the debounced LED select pattern and mode keys.
// Modes: static, blink, running light and (with LED_BREATH_EN defined)
// breathing PWM. Without LED_BREATH_EN the breathing logic is not built and
// MODE=11 renders exactly like static.
// Ports:
//   CLK_50M   in  1  board clock (single domain)
//   RST       in  1  synchronous active-high reset
//   LED_SEL   in  8  level-held LED select pattern
//   MODE      in  2  00 static, 01 blink, 10 running, 11 breathe
//   LED_OUT   out 8  registered LED drive, 1 = on
//   TICK_1MS  out 1  one-cycle pulse per millisecond
// Configuration macro: LED_BREATH_EN
// -----------------------------------------------------------------------------
module led_mode_driver
  import led_drv_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLINK_MS  = DEF_BLINK_MS,
  parameter int RUN_MS    = DEF_RUN_MS,
  parameter int BREATH_MS = DEF_BREATH_MS,
  parameter int PWM_STEPS = DEF_PWM_STEPS
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [7:0] LED_SEL,
  input  logic [1:0] MODE,
  output logic [7:0] LED_OUT,
  output logic       TICK_1MS
);

  localparam int PH_MAX = max3(BLINK_MS, RUN_MS, BREATH_MS);
  localparam int PH_W   = cnt_width(PH_MAX);

  // Reject configurations the counters cannot represent.
  if (PWM_STEPS < 2 || (PWM_STEPS & (PWM_STEPS - 1)) != 0) begin : g_bad_pwm
    $error("PWM_STEPS must be a power of two >= 2");
  end
  if (BLINK_MS < 1 || RUN_MS < 1 || BREATH_MS < 1 || TICK_DIV < 1) begin : g_bad_period
    $error("periods must be at least 1");
  end

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (CLK_50M),
    .rst  (RST),
    .tick (TICK_1MS)
  );

  mode_e            mode_q;
  logic             mode_chg;
  logic [PH_W-1:0]  ms_cnt;
  logic [PH_W-1:0]  ms_next;
  logic [PH_W-1:0]  ph_last;
  logic             ph_active;
  logic             blink_on;
  logic             blink_next;
  logic [7:0]       run_pat;
  logic [7:0]       run_next;
  logic [7:0]       led_next;

`ifdef LED_BREATH_EN
  localparam int PWM_W = cnt_width(PWM_STEPS);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_STEPS - 1);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] pwm_next;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_next;
  logic             dir_up;
  logic             dir_up_next;
`endif

  assign mode_chg = (MODE != mode_q);

  // Period of the phase counter for the mode currently being rendered.
  always_comb begin
    ph_active = 1'b0;
    ph_last   = '0;
    case (mode_q)
      MODE_BLINK: begin
        ph_active = 1'b1;
        ph_last   = PH_W'(BLINK_MS - 1);
      end
      MODE_RUN: begin
        ph_active = 1'b1;
        ph_last   = PH_W'(RUN_MS - 1);
      end
      MODE_BREATH: begin
`ifdef LED_BREATH_EN
        ph_active = 1'b1;
        ph_last   = PH_W'(BREATH_MS - 1);
`else
        ph_active = 1'b0;
        ph_last   = '0;
`endif
      end
      default: begin
        ph_active = 1'b0;
        ph_last   = '0;
      end
    endcase
  end

  // Next-state of the mode effects. A mode change restarts every phase and
  // swallows a tick arriving in the same cycle.
  always_comb begin
    ms_next    = ms_cnt;
    blink_next = blink_on;
    run_next   = run_pat;
`ifdef LED_BREATH_EN
    duty_next   = duty;
    dir_up_next = dir_up;
    if (pwm_cnt == PWM_LAST) pwm_next = '0;
    else                     pwm_next = pwm_cnt + PWM_W'(1);
`endif
    if (mode_chg) begin
      ms_next    = '0;
      blink_next = 1'b1;
      // An empty select would leave the running light dark forever.
      if (LED_SEL == 8'h00) run_next = 8'h01;
      else                  run_next = LED_SEL;
`ifdef LED_BREATH_EN
      duty_next   = '0;
      dir_up_next = 1'b1;
`endif
    end else if (TICK_1MS && ph_active) begin
      if (ms_cnt == ph_last) begin
        ms_next = '0;
        case (mode_q)
          MODE_BLINK: blink_next = ~blink_on;
          MODE_RUN:   run_next   = {run_pat[6:0], run_pat[7]};
          MODE_BREATH: begin
`ifdef LED_BREATH_EN
            // Triangle sweep: direction flips on reaching either end, so
            // duty never wraps.
            if (dir_up) begin
              duty_next = duty + PWM_W'(1);
              if (duty_next == PWM_LAST) dir_up_next = 1'b0;
              else                       dir_up_next = 1'b1;
            end else begin
              duty_next = duty - PWM_W'(1);
              if (duty_next == PWM_W'(0)) dir_up_next = 1'b1;
              else                        dir_up_next = 1'b0;
            end
`else
            ms_next = '0;
`endif
          end
          default: ms_next = '0;
        endcase
      end else begin
        ms_next = ms_cnt + PH_W'(1);
      end
    end else begin
      ms_next = ms_cnt;
    end
  end

  // Output pattern rendered from the state being loaded this edge.
  always_comb begin
    led_next = 8'h00;
    case (mode_e'(MODE))
      MODE_STATIC: led_next = LED_SEL;
      MODE_BLINK: begin
        if (blink_next) led_next = LED_SEL;
        else            led_next = 8'h00;
      end
      MODE_RUN: led_next = run_next;
      MODE_BREATH: begin
`ifdef LED_BREATH_EN
        if (pwm_cnt < duty_next) led_next = LED_SEL;
        else                     led_next = 8'h00;
`else
        led_next = LED_SEL;
`endif
      end
      default: led_next = 8'h00;
    endcase
  end

  // Mode, phase and output registers.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      mode_q   <= MODE_STATIC;
      ms_cnt   <= '0;
      blink_on <= 1'b1;
      run_pat  <= 8'h00;
      LED_OUT  <= 8'h00;
    end else begin
      mode_q   <= mode_e'(MODE);
      ms_cnt   <= ms_next;
      blink_on <= blink_next;
      run_pat  <= run_next;
      LED_OUT  <= led_next;
    end
  end

`ifdef LED_BREATH_EN
  // Breathing PWM registers.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      pwm_cnt <= '0;
      duty    <= '0;
      dir_up  <= 1'b1;
    end else begin
      pwm_cnt <= pwm_next;
      duty    <= duty_next;
      dir_up  <= dir_up_next;
    end
  end
`endif

endmodule

// File: tb/tb_led_mode_driver.sv
// -----------------------------------------------------------------------------
// tb_led_mode_driver
// Self-checking bench for led_mode_driver with small timing parameters.
// Reference model works from elapsed clocks/ticks: tick = clocks mod TICK_DIV,
// blink phase = ticks / BLINK_MS, run shift = ticks / RUN_MS, duty = triangle
// wave of ticks / BREATH_MS. Honours LED_BREATH_EN like the design.
// -----------------------------------------------------------------------------
module tb_led_mode_driver;

  localparam int TD = 4;
  localparam int BL = 2;
  localparam int RN = 2;
  localparam int BR = 1;
  localparam int PS = 4;
`ifdef LED_BREATH_EN
  localparam bit BREATH_ON = 1'b1;
`else
  localparam bit BREATH_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sel;
  logic [1:0] mode;
  logic [7:0] led;
  logic       tick;

  always #5 clk = ~clk;

  led_mode_driver #(
    .TICK_DIV  (TD),
    .BLINK_MS  (BL),
    .RUN_MS    (RN),
    .BREATH_MS (BR),
    .PWM_STEPS (PS)
  ) dut (
    .CLK_50M  (clk),
    .RST      (rst),
    .LED_SEL  (sel),
    .MODE     (mode),
    .LED_OUT  (led),
    .TICK_1MS (tick)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  int         n     = 0;   // clocks since reset release
  int         ticks = 0;   // ticks seen since mode entry
  int         mq    = 0;
  logic [7:0] start = 8'h00;
  logic [7:0] exp_led = 8'h00;
  logic       exp_tick = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic int tri_duty(input int k);
    int p;
    int r;
    p = 2 * (PS - 1);
    r = k % p;
    return (r <= PS - 1) ? r : p - r;
  endfunction

  task automatic model_edge();
    int         m;
    int         pw;
    logic       tb;
    if (rst) begin
      n = 0; mq = 0; ticks = 0; start = 8'h00;
      exp_led = 8'h00; exp_tick = 1'b0;
    end else begin
      tb = ((n % TD) == TD - 1);
      pw = n % PS;
      n++;
      if (int'(mode) != mq) begin
        ticks = 0;
        start = (sel == 8'h00) ? 8'h01 : sel;
      end else if (tb) begin
        ticks++;
      end
      mq = int'(mode);
      m  = int'(mode);
      if (!BREATH_ON && m == 3) m = 0;
      case (m)
        0:       exp_led = sel;
        1:       exp_led = (((ticks / BL) % 2) == 0) ? sel : 8'h00;
        2:       exp_led = rotl(start, (ticks / RN) % 8);
        default: exp_led = (pw < tri_duty(ticks / BR)) ? sel : 8'h00;
      endcase
      exp_tick = ((n % TD) == TD - 1);
    end
  endtask

  task automatic cycle(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq({tag, "_led"}, {24'h0, led}, {24'h0, exp_led});
      check_eq({tag, "_tick"}, {31'h0, tick}, {31'h0, exp_tick});
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b01; sel = 8'hFF;
    cycle("reset", 2);
    rst = 1'b0;
    cycle("tick", 9);

    // static, one clock latency
    mode = 2'b00; sel = 8'h00;
    cycle("static0", 2);
    sel = 8'h24;
    cycle("static", 1);
    check_eq("static_lat", {24'h0, led}, 32'h24);
    cycle("static", 2);

    // blink
    mode = 2'b01; sel = 8'h81;
    cycle("blink", 24);

    // running with wrap, then empty select
    mode = 2'b10; sel = 8'h80;
    cycle("run", 24);
    mode = 2'b00; cycle("run_exit", 1);
    mode = 2'b10; sel = 8'h00;
    cycle("run_zero", 12);

    // breathe (static when the feature is not built)
    mode = 2'b11; sel = 8'h0F;
    cycle("breath", 48);

    // mode change coinciding with a tick, then reset mid-blink
    mode = 2'b01; sel = 8'h3C;
    cycle("blink2", 6);
    for (int i = 0; i < TD && !exp_tick; i++) cycle("align", 1);
    check_eq("align_tick", {31'h0, tick}, 32'h1);
    mode = 2'b10;
    cycle("chg_tick", 1);
    mode = 2'b01;
    cycle("blink3", 5);
    rst = 1'b1;
    cycle("midrst", 1);
    check_eq("midrst_led", {24'h0, led}, 32'h0);
    rst = 1'b0;
    cycle("after_rst", 4);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      int len;
      mode = 2'($urandom_range(0, 3));
      sel  = 8'($urandom);
      len  = $urandom_range(4, 40);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cycle("rnd_rst", $urandom_range(1, 2));
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) sel = 8'($urandom);
        cycle("rnd", 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
